// File: rtl/cpu_mem_pkg.sv
// ============================================================================
// Module      : cpu_mem_pkg
// Description : Shared state encoding and defaults for the load/store engine.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_mem_pkg;

    localparam int DEFAULT_ADDR_W         = 27;
    localparam int DEFAULT_TIMEOUT_CYCLES = 1023;
    localparam logic [31:0] MEM_ERR_DATA  = 32'h0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_FIN  = 2'd3
    } mem_state_e;

endpackage

`default_nettype wire

// File: rtl/mem_addr_gen.sv
// ============================================================================
// Module      : mem_addr_gen
// Description : Effective address = base + sign-extended offset, with range check.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_addr_gen
    import cpu_mem_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W
) (
    input  logic [31:0]       base,
    input  logic [15:0]       offset,
    output logic [ADDR_W-1:0] ea,
    output logic              out_of_range
);

    logic [31:0] w_sum;

    assign w_sum = base + {{16{offset[15]}}, offset};
    assign ea    = w_sum[ADDR_W-1:0];

    // A full 32-bit bus has no unreachable addresses.
    generate
        if (ADDR_W < 32) begin : g_range_check
            assign out_of_range = |w_sum[31:ADDR_W];
        end else begin : g_no_range_check
            assign out_of_range = 1'b0;
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/mem_access_unit.sv
// ============================================================================
// Module      : mem_access_unit
// Description : Multi-cycle load/store engine with request/acknowledge bus.
//               Optional WAIT-state abort enabled by MEM_ACCESS_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_access_unit
    import cpu_mem_pkg::*;
#(
    parameter int ADDR_W         = DEFAULT_ADDR_W,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              is_store,
    input  logic [31:0]       base,
    input  logic [15:0]       offset,
    input  logic [31:0]       wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              read_mem,
    output logic [31:0]       mem_q,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [31:0]       bus_data,
    output logic              bus_we,
    output logic              bus_start,
    input  logic              bus_done,
    input  logic [31:0]       bus_q
);

    mem_state_e        r_state;
    mem_state_e        w_next_state;
    logic [ADDR_W-1:0] w_ea;
    logic              w_out_of_range;
    logic              w_timeout;

    logic [ADDR_W-1:0] r_bus_addr;
    logic [31:0]       r_bus_data;
    logic              r_bus_we;
    logic [31:0]       r_mem_q;
    logic              r_err;
    logic              r_rd_ok;

    mem_addr_gen #(
        .ADDR_W(ADDR_W)
    ) u_addr_gen (
        .base        (base),
        .offset      (offset),
        .ea          (w_ea),
        .out_of_range(w_out_of_range)
    );

`ifdef MEM_ACCESS_TIMEOUT_EN
    localparam int c_CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);

    logic [c_CNT_W-1:0] r_wait_cnt;

    // Held at zero outside WAIT, so it starts from zero on every entry.
    always_ff @(posedge clk) begin
        if (reset || (r_state != ST_WAIT)) begin
            r_wait_cnt <= '0;
        end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
        end
    end

    assign w_timeout = (r_state == ST_WAIT) && !bus_done && (r_wait_cnt == c_CNT_LAST);
`else
    logic w_unused_timeout;

    assign w_timeout        = 1'b0;
    assign w_unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (start) w_next_state = w_out_of_range ? ST_FIN : ST_REQ;
            ST_REQ:  w_next_state = ST_WAIT;
            ST_WAIT: if (bus_done || w_timeout) w_next_state = ST_FIN;
            ST_FIN:  w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // An acknowledge wins over a simultaneous timeout expiry.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_bus_addr <= '0;
            r_bus_data <= '0;
            r_bus_we   <= 1'b0;
            r_mem_q    <= '0;
            r_err      <= 1'b0;
            r_rd_ok    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_rd_ok <= 1'b0;
                        r_err   <= w_out_of_range;
                        if (!w_out_of_range) begin
                            r_bus_addr <= w_ea;
                            r_bus_data <= wdata;
                            r_bus_we   <= is_store;
                        end
                    end
                end
                ST_WAIT: begin
                    if (bus_done) begin
                        if (!r_bus_we) begin
                            r_mem_q <= bus_q;
                            r_rd_ok <= 1'b1;
                        end
                    end else if (w_timeout) begin
                        r_err   <= 1'b1;
                        r_mem_q <= MEM_ERR_DATA;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy      = (r_state != ST_IDLE);
    assign bus_start = (r_state == ST_REQ);
    assign done      = (r_state == ST_FIN);
    assign err       = done & r_err;
    assign read_mem  = done & r_rd_ok;
    assign mem_q     = r_mem_q;
    assign bus_addr  = r_bus_addr;
    assign bus_data  = r_bus_data;
    assign bus_we    = r_bus_we;

endmodule

`default_nettype wire
